axis_packet_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one 512-bit AXI-Stream sink between NUM_IN sources.

---
 rtl/axis_packet_rr_arbiter.sv | 119 +++++++++++
 tb/tb_axis_packet_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_IN AXI-Stream sources share one 512-bit sink.
// A granted source keeps the sink until its tlast beat transfers, so packets never interleave.
module axis_packet_rr_arbiter #(
   parameter int  NUM_IN        = 2,
   parameter int  TID_FROM_PORT = 0,
   parameter int  CNT_W         = 32,
   localparam int IDX_W         = $clog2(NUM_IN)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       s_axis_tvalid,
   output logic [NUM_IN-1:0]       s_axis_tready,
   input  logic [NUM_IN*512-1:0]   s_axis_tdata,
   input  logic [NUM_IN*64-1:0]    s_axis_tkeep,
   input  logic [NUM_IN*6-1:0]     s_axis_tid,
   input  logic [NUM_IN-1:0]       s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [511:0]            m_axis_tdata,
   output logic [63:0]             m_axis_tkeep,
   output logic [5:0]              m_axis_tid,
   output logic                    m_axis_tlast,
   output logic                    grant_valid,
   output logic [IDX_W-1:0]        grant_idx,
   output logic [NUM_IN*CNT_W-1:0] pkt_count
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t                         r_state, w_state_nxt;
   logic [IDX_W-1:0]               r_grant_idx, w_grant_nxt;
   logic [IDX_W-1:0]               r_rr_ptr, w_rr_nxt;
   logic [IDX_W-1:0]               w_cand, w_pick;
   logic                           w_pick_found;
   logic                           w_done;
   logic [NUM_IN-1:0][CNT_W-1:0]   r_pkt_count;

   logic [NUM_IN-1:0][511:0]       w_data;
   logic [NUM_IN-1:0][63:0]        w_keep;
   logic [NUM_IN-1:0][5:0]         w_tid;

   assign w_data = s_axis_tdata;
   assign w_keep = s_axis_tkeep;
   assign w_tid  = s_axis_tid;

   // First requester at or after rr_ptr, wrapping modulo NUM_IN.
   always_comb begin
      w_cand       = r_rr_ptr;
      w_pick       = r_rr_ptr;
      w_pick_found = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_IN);
         if (!w_pick_found && s_axis_tvalid[w_cand]) begin
            w_pick       = w_cand;
            w_pick_found = 1'b1;
         end
      end
   end

   // Payload follows the grant combinationally; only valid/ready are state-gated.
   always_comb begin
      m_axis_tdata = w_data[r_grant_idx];
      m_axis_tkeep = w_keep[r_grant_idx];
      m_axis_tlast = s_axis_tlast[r_grant_idx];
      m_axis_tid   = (TID_FROM_PORT != 0) ? 6'(r_grant_idx) : w_tid[r_grant_idx];
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant_idx;
      w_rr_nxt      = r_rr_ptr;
      w_done        = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_found) begin
               w_grant_nxt = w_pick;
               w_state_nxt = S_LOCKED;
            end
         end
         S_LOCKED: begin
            m_axis_tvalid              = s_axis_tvalid[r_grant_idx];
            s_axis_tready[r_grant_idx] = m_axis_tready;
            if (s_axis_tvalid[r_grant_idx] && m_axis_tready && s_axis_tlast[r_grant_idx]) begin
               w_done      = 1'b1;
               w_rr_nxt    = IDX_W'((32'(r_grant_idx) + 32'd1) % NUM_IN);
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A lock abandoned by reset must not leak a handshake during the reset cycle.
      if (reset) begin
         m_axis_tvalid = 1'b0;
         s_axis_tready = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
         r_pkt_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_idx <= w_grant_nxt;
         r_rr_ptr    <= w_rr_nxt;
         if (w_done)
            r_pkt_count[r_grant_idx] <= r_pkt_count[r_grant_idx] + CNT_W'(1);
      end
   end

   assign grant_valid = (r_state == S_LOCKED);
   assign grant_idx   = r_grant_idx;
   assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Bench for axis_packet_rr_arbiter: queued packet sources, a transaction-level arbitration
// model checked every cycle, and literal expectations for the directed scenarios.
module tb_axis_packet_rr_arbiter;

   localparam int N  = 2;
   localparam int CW = 32;
   localparam int IW = $clog2(N);

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic [5:0]   id;
      logic         l;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [N-1:0]          s_tvalid, s_tlast;
   logic [N-1:0][511:0]   s_tdata;
   logic [N-1:0][63:0]    s_tkeep;
   logic [N-1:0][5:0]     s_tid;
   logic [N-1:0]          s_tready_a, s_tready_b;
   logic                  m_tready = 1'b1;
   logic                  m_tvalid_a, m_tlast_a, gv_a, m_tvalid_b, m_tlast_b, gv_b;
   logic [511:0]          m_tdata_a, m_tdata_b;
   logic [63:0]           m_tkeep_a, m_tkeep_b;
   logic [5:0]            m_tid_a, m_tid_b;
   logic [IW-1:0]         gi_a, gi_b;
   logic [N*CW-1:0]       pkt_a, pkt_b;

   always #5 clk = ~clk;

   axis_packet_rr_arbiter #(.NUM_IN(N), .TID_FROM_PORT(0), .CNT_W(CW)) u_dut_a (
      .clock(clk), .reset(reset),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_a),
      .m_axis_tkeep(m_tkeep_a), .m_axis_tid(m_tid_a), .m_axis_tlast(m_tlast_a),
      .grant_valid(gv_a), .grant_idx(gi_a), .pkt_count(pkt_a));

   axis_packet_rr_arbiter #(.NUM_IN(N), .TID_FROM_PORT(1), .CNT_W(CW)) u_dut_b (
      .clock(clk), .reset(reset),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_b),
      .m_axis_tkeep(m_tkeep_b), .m_axis_tid(m_tid_b), .m_axis_tlast(m_tlast_b),
      .grant_valid(gv_b), .grant_idx(gi_b), .pkt_count(pkt_b));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- sources ----------------
   beat_t        q0[$], q1[$];
   logic [N-1:0] en = '0;

   task automatic add_pkt(input int s, input int nb, input logic [5:0] id);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         for (int w = 0; w < 16; w++) b.d[w*32 +: 32] = $urandom();
         b.k  = {$urandom(), $urandom()};
         b.id = id;
         b.l  = (i == nb - 1);
         if (s == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic drive_now();
      beat_t b0, b1;
      b0 = (q0.size() > 0) ? q0[0] : '0;
      b1 = (q1.size() > 0) ? q1[0] : '0;
      s_tvalid[0] = en[0] && (q0.size() > 0);
      s_tvalid[1] = en[1] && (q1.size() > 0);
      s_tdata[0] = b0.d;  s_tdata[1] = b1.d;
      s_tkeep[0] = b0.k;  s_tkeep[1] = b1.k;
      s_tid[0]   = b0.id; s_tid[1]   = b1.id;
      s_tlast[0] = b0.l;  s_tlast[1] = b1.l;
   endtask

   initial begin : drv
      logic f0, f1;
      drive_now();
      forever begin
         @(negedge clk);
         f0 = s_tvalid[0] && s_tready_a[0];
         f1 = s_tvalid[1] && s_tready_a[1];
         @(posedge clk);
         #1;
         if (f0 && q0.size() > 0) void'(q0.pop_front());
         if (f1 && q1.size() > 0) void'(q1.pop_front());
         drive_now();
      end
   end

   // ---------------- model + per-cycle compare + logs ----------------
   bit            mdl_locked = 1'b0;
   logic [IW-1:0] mdl_owner = '0;
   logic [IW-1:0] mdl_next = '0;
   logic [CW-1:0] mdl_cnt [N] = '{default: '0};
   logic [IW-1:0] cand;
   bit            found;
   logic          exp_valid;
   logic [N-1:0]  exp_ready;

   int            cyc = 0;
   int            grant_log[$], grant_cyc[$];
   logic [5:0]    tid_log[$];
   logic [5:0]    tid_b_last;
   int            beats_src [N];
   int            ready_leak, stall_change, n_stall, s1_wait;
   logic          prev_gv = 1'b0, prev_stall = 1'b0;
   logic [582:0]  prev_bus;

   always @(negedge clk) begin
      cyc++;
      exp_valid = 1'b0;
      exp_ready = '0;
      if (!reset && mdl_locked) begin
         exp_valid            = s_tvalid[mdl_owner];
         exp_ready[mdl_owner] = m_tready;
      end
      chk("m_tvalid", m_tvalid_a, exp_valid);
      chk("s_tready", s_tready_a, exp_ready);
      chk("m_tvalid_b", m_tvalid_b, exp_valid);
      chk("s_tready_b", s_tready_b, exp_ready);
      chk("grant_valid", gv_a, mdl_locked);
      chk("grant_idx", gi_a, mdl_owner);
      chk("pkt_count", pkt_a, {mdl_cnt[1], mdl_cnt[0]});
      if (exp_valid) begin
         chk("m_tdata", m_tdata_a, s_tdata[mdl_owner]);
         chk("m_tkeep", m_tkeep_a, s_tkeep[mdl_owner]);
         chk("m_tid", m_tid_a, s_tid[mdl_owner]);
         chk("m_tid_port", m_tid_b, 6'(mdl_owner));
         chk("m_tlast", m_tlast_a, s_tlast[mdl_owner]);
      end

      if (gv_a && !prev_gv) begin
         grant_log.push_back(int'(gi_a));
         grant_cyc.push_back(cyc);
      end
      prev_gv = gv_a;
      if (m_tvalid_a && m_tready) begin
         beats_src[gi_a]++;
         tid_log.push_back(m_tid_a);
         tid_b_last = m_tid_b;
      end
      if (s_tready_a[0] && !(gv_a && gi_a == 0)) ready_leak++;
      if (s_tready_a[1] && !(gv_a && gi_a == 1)) ready_leak++;
      if (s_tvalid[1] && !s_tready_a[1] && gv_a && gi_a == 0) s1_wait++;
      if (prev_stall && {m_tdata_a, m_tkeep_a, m_tid_a, m_tlast_a} != prev_bus) stall_change++;
      prev_stall = m_tvalid_a && !m_tready;
      if (prev_stall) n_stall++;
      prev_bus = {m_tdata_a, m_tkeep_a, m_tid_a, m_tlast_a};

      // Transaction-level arbitration rules.
      if (reset) begin
         mdl_locked = 1'b0;
         mdl_owner  = '0;
         mdl_next   = '0;
         mdl_cnt    = '{default: '0};
      end else if (!mdl_locked) begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            cand = IW'((int'(mdl_next) + k) % N);
            if (!found && s_tvalid[cand]) begin
               found      = 1'b1;
               mdl_owner  = cand;
               mdl_locked = 1'b1;
            end
         end
      end else if (s_tvalid[mdl_owner] && m_tready && s_tlast[mdl_owner]) begin
         mdl_cnt[mdl_owner] = mdl_cnt[mdl_owner] + 1;
         mdl_next           = IW'((int'(mdl_owner) + 1) % N);
         mdl_locked         = 1'b0;
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      tid_log.delete();
      beats_src    = '{default: 0};
      ready_leak   = 0;
      stall_change = 0;
      n_stall      = 0;
      s1_wait      = 0;
   endtask

   task automatic wait_done(input string name, input int budget, input bit toggle_ready);
      int i = 0;
      while ((q0.size() > 0 || q1.size() > 0 || gv_a) && i < budget) begin
         step();
         if (toggle_ready) m_tready = ~m_tready;
         i++;
      end
      m_tready = 1'b1;
      chk(name, 512'(i < budget), 512'd1);
      step();
   endtask

   task automatic wait_beats(input string name, input int s, input int n, input int budget);
      int i = 0;
      while (beats_src[s] < n && i < budget) begin
         step();
         i++;
      end
      chk(name, 512'(i < budget), 512'd1);
   endtask

   initial begin
      clear_logs();
      repeat (2) step();
      reset = 1'b0;

      // T1: quiet outputs for two cycles after reset release
      for (int c = 0; c < 2; c++) begin
         step();
         chk("t1_m_tvalid", m_tvalid_a, 0);
         chk("t1_s_tready", s_tready_a, 0);
         chk("t1_pkt_count", pkt_a, 0);
      end

      // T2: both sources always valid, 3-beat packets
      clear_logs();
      add_pkt(0, 3, 6'h10); add_pkt(0, 3, 6'h10);
      add_pkt(1, 3, 6'h2A); add_pkt(1, 3, 6'h2A);
      en = 2'b11;
      wait_done("t2_timeout", 60, 1'b0);
      chk("t2_ngrants", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
      for (int i = 1; i < 4; i++) chk($sformatf("t2_period%0d", i), grant_cyc[i] - grant_cyc[i-1], 4);
      chk("t2_pkt_count", pkt_a, 64'h00000002_00000002);
      chk("t2_beats0", beats_src[0], 6);
      chk("t2_beats1", beats_src[1], 6);

      // T3: source1 requests mid-packet of source0
      clear_logs();
      en = 2'b01;
      add_pkt(0, 4, 6'h11); add_pkt(1, 1, 6'h2B);
      wait_beats("t3_beat1_timeout", 0, 1, 20);
      en = 2'b11;
      wait_done("t3_timeout", 40, 1'b0);
      chk("t3_nbeats", tid_log.size(), 5);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_tid%0d", i), tid_log[i], 6'h11);
      chk("t3_tid4", tid_log[4], 6'h2B);
      chk("t3_grant0", grant_log[0], 0);
      chk("t3_grant1", grant_log[1], 1);
      chk("t3_s1_waited", 512'(s1_wait > 0), 512'd1);
      chk("t3_ready_leak", ready_leak, 0);

      // T4: sink ready toggling during a 4-beat packet
      clear_logs();
      en = 2'b01;
      add_pkt(0, 4, 6'h12);
      wait_done("t4_timeout", 40, 1'b1);
      chk("t4_beats", beats_src[0], 4);
      chk("t4_stalled", 512'(n_stall > 0), 512'd1);
      chk("t4_stall_change", stall_change, 0);
      chk("t4_pkt_count", pkt_a, 64'h00000003_00000004);

      // T5: tid pass-through vs source index
      clear_logs();
      en = 2'b10;
      add_pkt(1, 1, 6'h2A);
      wait_done("t5_timeout", 20, 1'b0);
      chk("t5_tid_pass", tid_log[0], 6'h2A);
      chk("t5_tid_port", tid_b_last, 6'h01);

      // T6: reset mid-packet with rr_ptr pointing at source1 beforehand
      en = 2'b01;
      add_pkt(0, 1, 6'h13);
      wait_done("t6_pre_timeout", 20, 1'b0);
      clear_logs();
      en = 2'b10;
      add_pkt(1, 4, 6'h14);
      wait_beats("t6_beat2_timeout", 1, 2, 20);
      reset = 1'b1;
      en    = 2'b00;
      q1.delete();
      step();
      reset = 1'b0;
      chk("t6_grant_valid", gv_a, 0);
      chk("t6_pkt_count", pkt_a, 0);
      chk("t6_beats_cut", beats_src[1], 2);
      step();
      chk("t6_idle_tvalid", m_tvalid_a, 0);
      clear_logs();
      add_pkt(0, 1, 6'h15); add_pkt(1, 1, 6'h16);
      en = 2'b11;
      wait_done("t6_post_timeout", 20, 1'b0);
      chk("t6_grant0", grant_log[0], 0);
      chk("t6_grant1", grant_log[1], 1);
      chk("t6_pkt_count_after", pkt_a, 64'h00000001_00000001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
